// File: rtl/addr_decoder_pkg.sv
// Shared address-map helpers and loader state encoding for the address decoder
// configuration path (BASE/MASK/SLOT/OP byte tables).
package addr_decoder_pkg;

  localparam int         SLOT_W     = 3;
  localparam logic [7:0] OP_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHK     = 3'd1,
    ST_WIN     = 3'd2,
    ST_CLR     = 3'd3,
    ST_FIN     = 3'd4,
    ST_FIN_ERR = 3'd5
  } loader_state_e;

  function automatic int cfg_bytes(input int addr_w);
    return (addr_w + 7) / 8;
  endfunction

  function automatic int mask_off(input int addr_w, input int num_win);
    return num_win * cfg_bytes(addr_w);
  endfunction

  function automatic int slot_off(input int addr_w, input int num_win);
    return 2 * mask_off(addr_w, num_win);
  endfunction

  function automatic int op_off(input int addr_w, input int num_win);
    return slot_off(addr_w, num_win) + num_win;
  endfunction

  function automatic int cfg_total(input int addr_w, input int num_win);
    return op_off(addr_w, num_win) + num_win;
  endfunction

endpackage

// File: rtl/addr_decoder_cfg_loader.sv
// Serializes whole-window or CLEAR commands into one config byte write per clock
// for the address decoder's BASE/MASK/SLOT/OP tables.
module addr_decoder_cfg_loader
  import addr_decoder_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_WIN = 16,
  parameter int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic              cfg_clk,
  input  logic              cfg_rst_n,
  // A command transfers on a rising edge where req_valid && req_ready; req_ready
  // is high only in IDLE, so req_valid held while busy waits for the next IDLE.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_clear,
  input  logic [WIN_W-1:0]  req_win,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_mask,
  input  logic [SLOT_W-1:0] req_slot,
  input  logic [7:0]        req_op,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cfg_we,
  output logic [7:0]        cfg_addr,
  output logic [7:0]        cfg_wdata,
  output logic [2:0]        dbg_state
);

  localparam int CB    = cfg_bytes(ADDR_W);
  localparam int MOFF  = mask_off(ADDR_W, NUM_WIN);
  localparam int SOFF  = slot_off(ADDR_W, NUM_WIN);
  localparam int OOFF  = op_off(ADDR_W, NUM_WIN);
  localparam int TOT   = cfg_total(ADDR_W, NUM_WIN);
  localparam int CNT_W = $clog2(TOT + 1);
  localparam int PAD_W = CB * 8;

  localparam logic [CNT_W-1:0] WIN_N     = CNT_W'(2 * CB + 2);
  localparam logic [CNT_W-1:0] TOT_N     = CNT_W'(TOT);
  localparam logic [WIN_W:0]   NUM_WIN_L = (WIN_W + 1)'(NUM_WIN);

  if (TOT > 256) begin : g_bad_cfg
    $error("addr_decoder_cfg_loader: config table exceeds the 8-bit address space");
  end

  loader_state_e     r_state;
  logic              r_clear;
  logic [WIN_W-1:0]  r_win;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_mask;
  logic [SLOT_W-1:0] r_slot;
  logic [7:0]        r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [7:0]        r_addr;
  logic [7:0]        r_wdata;

  logic [PAD_W-1:0]  w_base_pad;
  logic [PAD_W-1:0]  w_mask_pad;
  logic [CNT_W-1:0]  w_idx;
  logic [CNT_W-1:0]  w_last_n;
  logic              w_win_bad;
  logic [7:0]        w_addr;
  logic [7:0]        w_data;

  // Zero-extension keeps the bits of the top byte above ADDR_W at 0.
  assign w_base_pad = PAD_W'(r_base);
  assign w_mask_pad = PAD_W'(r_mask);

  // CHK launches byte 0; WIN/CLR launch the byte the counter points at.
  assign w_idx     = (r_state == ST_CHK) ? '0 : r_cnt;
  assign w_last_n  = r_clear ? TOT_N : WIN_N;
  assign w_win_bad = !r_clear && ({1'b0, r_win} >= NUM_WIN_L);

  always_comb begin
    int i;
    int wb;
    w_addr = 8'h00;
    w_data = 8'h00;
    i      = int'(w_idx);
    wb     = int'(r_win) * CB;
    if (r_clear) begin
      w_addr = 8'(i);
      w_data = (i >= OOFF) ? OP_DEFAULT : 8'h00;
    end else if (i < CB) begin
      w_addr = 8'(wb + i);
      w_data = w_base_pad[i*8 +: 8];
    end else if (i < 2 * CB) begin
      w_addr = 8'(MOFF + wb + i - CB);
      w_data = w_mask_pad[(i-CB)*8 +: 8];
    end else if (i == 2 * CB) begin
      w_addr = 8'(SOFF + int'(r_win));
      w_data = {{(8-SLOT_W){1'b0}}, r_slot};
    end else begin
      w_addr = 8'(OOFF + int'(r_win));
      w_data = r_op;
    end
  end

  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      r_state <= ST_IDLE;
      r_clear <= 1'b0;
      r_win   <= '0;
      r_base  <= '0;
      r_mask  <= '0;
      r_slot  <= '0;
      r_op    <= 8'h00;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_clear <= req_clear;
            r_win   <= req_win;
            r_base  <= req_base;
            r_mask  <= req_mask;
            r_slot  <= req_slot;
            r_op    <= req_op;
            r_state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (w_win_bad) begin
            r_state <= ST_FIN_ERR;
          end else begin
            r_we    <= 1'b1;
            r_addr  <= w_addr;
            r_wdata <= w_data;
            r_cnt   <= CNT_W'(1);
            r_state <= r_clear ? ST_CLR : ST_WIN;
          end
        end
        ST_WIN, ST_CLR: begin
          if (r_cnt == w_last_n) begin
            r_cnt   <= '0;
            r_state <= ST_FIN;
          end else begin
            r_we    <= 1'b1;
            r_addr  <= w_addr;
            r_wdata <= w_data;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIN, ST_FIN_ERR: r_state <= ST_IDLE;
        default:            r_state <= ST_IDLE;
      endcase
    end
  end

  // Gating with the reset pin holds req_ready low for as long as reset is asserted.
  assign req_ready = (r_state == ST_IDLE) && cfg_rst_n;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FIN);
  assign err       = (r_state == ST_FIN_ERR);
  assign cfg_we    = r_we;
  assign cfg_addr  = r_addr;
  assign cfg_wdata = r_wdata;
  assign dbg_state = r_state;

endmodule

// File: doc/addr_decoder_cfg_loader.md
Name: addr_decoder_cfg_loader

Overview:
- Sequencer that drives the byte-wide config port (cfg_we/cfg_addr/cfg_wdata) of the address decoder's BASE/MASK/SLOT/OP tables.
- Accepts whole-window commands over a valid/ready handshake and serializes each into one byte write per clock.
- Also supports a CLEAR command that sweeps every table entry back to its power-on default.
- Sits between the Dock host/config register block and the decoder config storage.

Parameters:
- ADDR_W, 32, width of each BASE/MASK field.
- NUM_WIN, 16, number of decode windows.
- WIN_W, $clog2(NUM_WIN) (min 1), width of the window index.

Ports:
- cfg_clk  in  1  sole clock.
- cfg_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  loader can accept a command.
- req_clear  in  1  1 = CLEAR all windows; window fields ignored.
- req_win  in  WIN_W  target window.
- req_base  in  ADDR_W  BASE value.
- req_mask  in  ADDR_W  MASK value.
- req_slot  in  3  SLOT value.
- req_op  in  8  OP value.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse when a command is rejected.
- cfg_we  out  1  config byte write strobe.
- cfg_addr  out  8  config byte address.
- cfg_wdata  out  8  config byte data.

Behaviour:
- Address map constants:
  - CFG_BYTES = ceil(ADDR_W/8).
  - MASK_OFF = NUM_WIN*CFG_BYTES.
  - SLOT_OFF = 2*MASK_OFF.
  - OP_OFF = SLOT_OFF + NUM_WIN.
  - CFG_TOTAL = OP_OFF + NUM_WIN.
  - CFG_TOTAL > 256 is an elaboration error.
- Reset (async, cfg_rst_n low): FSM=IDLE, req_ready=0 while in reset, busy=0, done=0, err=0, cfg_we=0, cfg_addr=0, cfg_wdata=0.
  - Reset mid-sequence aborts immediately; cfg_we drops asynchronously.
  - Tables may be left partially written; the host re-issues the command.
- FSM states:
  - IDLE: req_ready=1, busy=0. On req_valid&&req_ready, capture all req_* fields and go to CHK.
  - CHK: 1 cycle, busy=1, req_ready=0. Go to FIN_ERR if !req_clear and req_win >= NUM_WIN; else go to WIN if !req_clear; else go to CLR.
  - WIN: emits 2*CFG_BYTES+2 consecutive writes, one per cycle:
    - BASE bytes LSB first at w*CFG_BYTES+b.
    - MASK bytes LSB first at MASK_OFF+w*CFG_BYTES+b.
    - SLOT at SLOT_OFF+w, data {5'b0,slot}.
    - OP at OP_OFF+w.
    - Then go to FIN.
  - CLR: emits CFG_TOTAL writes at addresses 0..CFG_TOTAL-1 ascending. Data is 0x00 for addr < OP_OFF, 0xFF for addr >= OP_OFF. Then go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
  - FIN_ERR: err=1 for one cycle, no writes issued, then IDLE.
- Output timing:
  - cfg_* are registered. The first write is valid in the cycle after CHK; writes are back-to-back with no gaps.
  - Acceptance at edge T gives: CHK in cycle T+1, writes in T+2..T+1+N, done in T+2+N, req_ready=1 in T+3+N.
- Width rules:
  - When ADDR_W%8 != 0, the bits of the top byte above ADDR_W are driven 0.
  - Byte counter width is $clog2(CFG_TOTAL+1). It never wraps; the terminal count is compared exactly.
- Other boundaries:
  - req_valid held during busy is ignored; the command is not captured until req_ready.
  - Input changes after acceptance have no effect, since all fields are captured.
  - done and err are never both high.

Decomposition:
- Package addr_decoder_pkg holds:
  - function cfg_bytes(ADDR_W).
  - functions for MASK_OFF/SLOT_OFF/OP_OFF/CFG_TOTAL(ADDR_W, NUM_WIN).
  - OP_DEFAULT=8'hFF, SLOT_W=3.
  - loader state enum {IDLE, CHK, WIN, CLR, FIN, FIN_ERR}.
- addr_decoder_cfg should migrate to the same offset functions.
- No sub-module: a single FSM plus a byte counter and an address/data mux.

Test Plan:
- Defaults ADDR_W=32, NUM_WIN=16 (MASK_OFF=64, SLOT_OFF=128, OP_OFF=144, CFG_TOTAL=160).
- Write win 3, base 0x12345678, mask 0xFFFF0000, slot 5, op 0xA5:
  - Exactly 10 writes: 12:78, 13:56, 14:34, 15:12, 76:00, 77:00, 78:FF, 79:FF, 131:05, 147:A5.
  - done pulses 12 cycles after acceptance.
  - With addr_decoder_cfg attached, base window 3 = 0x12345678 and op window 3 = 0xA5.
- CLEAR after several window writes:
  - 160 consecutive writes.
  - All base/mask/slot read back 0 and all op = 0xFF.
  - Single done pulse.
- NUM_WIN=12, req_win=13:
  - No cfg_we.
  - err pulses 2 cycles after acceptance.
  - req_ready returns the next cycle.
- Assert cfg_rst_n low during the 5th write of a window command:
  - cfg_we=0 immediately.
  - After release, req_ready=1 and busy=0.
  - Re-issuing the command completes normally.
- Hold req_valid high with new fields while busy:
  - The second command is accepted only after done.
  - Its writes follow contiguously.
  - The first command's bytes are unaffected by the changed inputs.
- ADDR_W=20:
  - CFG_BYTES=3.
  - The top base byte for base 0xABCDE is 0x0A, with bits 7:4 = 0.
  - 8 writes per window.
